// File: rtl/sorted_merge_stream_pkg.sv
// Shared defaults, state encoding and pointer-width helper for sorted_merge_stream.
// Optional checker is enabled with the SORT_CHECK_EN macro (see the top).
package merge_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_N      = 8;
   localparam int IDX_W      = $clog2(DEF_N + 1);

   typedef enum logic {
      IDLE,
      MERGE
   } state_t;

   // Pointers must reach N itself, which marks a list as exhausted.
   function automatic int idx_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/sorted_merge_stream_select.sv
// Head selector for the two-way merge: stable, ties go to list A.
module merge_select #(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] a_head,
   input  logic [DATA_W-1:0] b_head,
   input  logic              a_done,
   input  logic              b_done,
   output logic [DATA_W-1:0] sel_data,
   output logic              take_a
);

   always_comb begin
      take_a   = b_done || (!a_done && (a_head <= b_head));
      sel_data = take_a ? a_head : b_head;
   end

endmodule

// File: rtl/sorted_merge_stream.sv
// Two-way streaming merger: accepts two sorted N-element vectors, emits 2N elements ascending.
// Define SORT_CHECK_EN to build the sticky input-order checker driving sort_err.
//
// state | meaning
// IDLE  | waiting for a vector pair, in_ready=1
// MERGE | emitting merged elements, one per out handshake
module sorted_merge_stream
   import merge_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int N      = DEF_N
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [N*DATA_W-1:0] a_vec,
   input  logic [N*DATA_W-1:0] b_vec,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   out_data,
   output logic                out_last,
   output logic                sort_err
);

   localparam int PW = idx_w(N);

   state_t              state_q, state_d;
   logic [N*DATA_W-1:0] a_buf, b_buf;
   logic [PW-1:0]       ia, ib;
   logic                a_done, b_done;
   logic [DATA_W-1:0]   a_head, b_head, sel_data;
   logic                take_a, last_elem;
   logic                accept, fire;

   assign a_done    = (ia == PW'(N));
   assign b_done    = (ib == PW'(N));
   assign last_elem = ((int'(ia) + int'(ib)) == (2 * N - 1));

   // Exhausted pointers are clamped so the part-select stays in range.
   always_comb begin
      a_head = a_buf[(a_done ? 0 : int'(ia)) * DATA_W +: DATA_W];
      b_head = b_buf[(b_done ? 0 : int'(ib)) * DATA_W +: DATA_W];
   end

   merge_select #(.DATA_W(DATA_W)) u_select (
      .a_head   (a_head),
      .b_head   (b_head),
      .a_done   (a_done),
      .b_done   (b_done),
      .sel_data (sel_data),
      .take_a   (take_a)
   );

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
      out_last  = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = MERGE;
         end
         MERGE: begin
            out_valid = 1'b1;
            out_data  = sel_data;
            out_last  = last_elem;
            if (out_ready && last_elem) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign accept = in_valid && in_ready;
   assign fire   = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_buf   <= '0;
         b_buf   <= '0;
         ia      <= '0;
         ib      <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            a_buf <= a_vec;
            b_buf <= b_vec;
            ia    <= '0;
            ib    <= '0;
         end else if (fire) begin
            if (take_a) ia <= ia + 1'b1;
            else        ib <= ib + 1'b1;
         end
      end
   end

`ifdef SORT_CHECK_EN
   logic unsorted;
   logic err_q;

   always_comb begin
      unsorted = 1'b0;
      for (int i = 0; i < N - 1; i++) begin
         if (a_vec[i*DATA_W +: DATA_W] > a_vec[(i+1)*DATA_W +: DATA_W]) unsorted = 1'b1;
         if (b_vec[i*DATA_W +: DATA_W] > b_vec[(i+1)*DATA_W +: DATA_W]) unsorted = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                     err_q <= 1'b0;
      else if (accept && unsorted) err_q <= 1'b1;
   end

   assign sort_err = err_q;
`else
   assign sort_err = 1'b0;
`endif

endmodule

// File: tb/tb_sorted_merge_stream.sv
// Directed bench for sorted_merge_stream with an expected-output queue.
module tb_sorted_merge_stream;

   localparam int DW = 8;
   localparam int NE = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [NE*DW-1:0] a_vec, b_vec;
   logic             out_valid;
   logic             out_ready;
   logic [DW-1:0]    out_data;
   logic             out_last;
   logic             sort_err;

   int checks   = 0;
   int failures = 0;
   logic [DW-1:0] exp_q[$];

`ifdef SORT_CHECK_EN
   localparam logic ERR_ON = 1'b1;
`else
   localparam logic ERR_ON = 1'b0;
`endif

   sorted_merge_stream #(.DATA_W(DW), .N(NE)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_vec     (a_vec),
      .b_vec     (b_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .sort_err  (sort_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [NE*DW-1:0] mk(input int v0, input int step);
      logic [NE*DW-1:0] v;
      for (int i = 0; i < NE; i++) v[i*DW +: DW] = DW'(v0 + i * step);
      return v;
   endfunction

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input logic [NE*DW-1:0] a, input logic [NE*DW-1:0] b);
      logic [DW-1:0] tmp[$];
      int w = 0;
      in_valid = 1'b1;
      a_vec    = a;
      b_vec    = b;
      while (!in_ready && w < 50) begin
         cyc();
         w++;
      end
      chk("in_ready_before_accept", in_ready, 1);
      cyc();
      in_valid = 1'b0;
      chk("out_valid_after_accept", out_valid, 1);
      chk("in_ready_in_merge", in_ready, 0);
      for (int i = 0; i < NE; i++) begin
         tmp.push_back(a[i*DW +: DW]);
         tmp.push_back(b[i*DW +: DW]);
      end
      tmp.sort();
      foreach (tmp[i]) exp_q.push_back(tmp[i]);
   endtask

   // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0 repeating.
   // abort_after >= 0 returns after that many transfers (block left unfinished).
   task automatic drain(input int mode, input bit cmp_vals, input int abort_after);
      int n = 0;
      int c = 0;
      bit stalled = 1'b0;
      logic [DW-1:0] hd;
      logic hl;
      logic [DW-1:0] e;
      while (exp_q.size() > 0 && c < 200) begin
         out_ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
         chk("out_valid_during_block", out_valid, 1);
         if (stalled) begin
            chk("stall_data_hold", out_data, hd);
            chk("stall_last_hold", out_last, hl);
         end
         if (out_valid && out_ready) begin
            e = exp_q.pop_front();
            if (cmp_vals) chk("out_data", out_data, e);
            chk("out_last", out_last, (exp_q.size() == 0));
            n++;
            stalled = 1'b0;
         end else begin
            stalled = 1'b1;
            hd = out_data;
            hl = out_last;
         end
         c++;
         cyc();
         if (abort_after >= 0 && n == abort_after) begin
            out_ready = 1'b1;
            return;
         end
      end
      chk("drain_completed", exp_q.size(), 0);
      chk("in_ready_after_last", in_ready, 1);
      chk("out_valid_after_last", out_valid, 0);
      out_ready = 1'b1;
   endtask

   initial begin
      logic [NE*DW-1:0] bad_a;
      rst       = 1'b1;
      in_valid  = 1'b0;
      a_vec     = '0;
      b_vec     = '0;
      out_ready = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_sort_err", sort_err, 0);

      // interleaved odd/even lists
      send(mk(1, 2), mk(2, 2));
      drain(0, 1'b1, -1);

      // all ties
      send(mk(8, 0), mk(8, 0));
      drain(0, 1'b1, -1);

      // A exhausted before any B element is taken
      send(mk(0, 1), mk(200, 1));
      drain(0, 1'b1, -1);

      // backpressure with mixed lists
      send(mk(3, 5), mk(1, 7));
      drain(1, 1'b1, -1);

      // reset mid-block after five outputs
      send(mk(10, 3), mk(11, 3));
      drain(0, 1'b1, 5);
      rst = 1'b1;
      cyc();
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 1);
      rst = 1'b0;
      exp_q.delete();
      send(mk(50, 4), mk(52, 1));
      drain(0, 1'b1, -1);

      // unsorted A: 5,4,6,7,...
      bad_a = mk(4, 1);
      bad_a[0 +: DW]  = 8'd5;
      bad_a[DW +: DW] = 8'd4;
      send(bad_a, mk(2, 2));
      chk("sort_err_after_bad", sort_err, ERR_ON);
      drain(0, 1'b0, -1);
      chk("sort_err_sticky_idle", sort_err, ERR_ON);
      send(mk(1, 1), mk(1, 1));
      chk("sort_err_sticky_good", sort_err, ERR_ON);
      drain(0, 1'b1, -1);
      chk("sort_err_sticky_end", sort_err, ERR_ON);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("sort_err_cleared", sort_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
